picc_tx_scheduler: RTL and testbench

PICC_TX_SCHEDULER -- requirements
Module: picc_tx_scheduler

---
 rtl/rfid_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/picc_tx_scheduler.sv | 170 +++++++++++++++++
 tb/tb_picc_tx_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfid_pkg.sv
// Shared types and constants for the PICC transmit path.
package rfid_pkg;

    localparam int unsigned MAX_FRAME_BYTES = 5;
    localparam int unsigned FRAME_W         = 40;
    localparam int unsigned NB_W            = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone,
        StGuard
    } sched_state_e;

    function automatic logic len_ok(input logic [NB_W-1:0] n);
        return (n != '0) && (n <= NB_W'(MAX_FRAME_BYTES));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: scans from the slot after i_last, wrapping, first request wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [1:0]         i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [1:0]         o_idx,
    output logic               o_valid
);

    logic [1:0] w_cand;
    logic       w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = 2'((32'(i_last) + k) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/picc_tx_scheduler.sv
// Arbitrates frame requesters onto the PICC encoder and enforces the inter-frame guard time.
module picc_tx_scheduler
    import rfid_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned GUARD_CYCLES = 1152,
    parameter int unsigned ACK_TIMEOUT  = 4096
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       enable_in,
    input  logic [NUM_REQ-1:0]         req_valid_in,
    input  logic [NUM_REQ*FRAME_W-1:0] req_data_in,
    input  logic [NUM_REQ*NB_W-1:0]    req_num_bytes_in,
    output logic [NUM_REQ-1:0]         req_ack_out,
    output logic [NUM_REQ-1:0]         req_reject_out,
    output logic [FRAME_W-1:0]         tx_data_out,
    output logic [NB_W-1:0]            tx_num_bytes_out,
    output logic                       tx_trigger_out,
    input  logic                       tx_busy_in,
    input  logic                       tx_done_in,
    output logic [1:0]                 grant_id_out,
    output logic                       sched_busy_out,
    output logic                       timeout_out,
    output logic [15:0]                frame_cnt_out
);

    localparam int unsigned CNT_MAX    = (ACK_TIMEOUT > GUARD_CYCLES) ? ACK_TIMEOUT : GUARD_CYCLES;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

    sched_state_e r_state, w_state_d;

    logic [CNT_W-1:0]   r_cnt, w_cnt_d;
    logic [1:0]         r_last, w_last_d;
    logic [1:0]         r_gid, w_gid_d;
    logic [FRAME_W-1:0] r_data, w_data_d;
    logic [NB_W-1:0]    r_nb, w_nb_d;
    logic [15:0]        r_frame_cnt, w_frame_cnt_d;
    logic [NUM_REQ-1:0] r_ack, w_ack;
    logic [NUM_REQ-1:0] r_reject, w_reject;
    logic               r_trigger, w_trigger;
    logic               r_timeout, w_timeout;

    logic [NUM_REQ-1:0] w_arb_grant;
    logic [1:0]         w_arb_idx;
    logic               w_arb_valid;
    logic [FRAME_W-1:0] w_sel_data;
    logic [NB_W-1:0]    w_sel_nb;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req   (req_valid_in),
        .i_last  (r_last),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_sel_data = req_data_in[FRAME_W*w_arb_idx +: FRAME_W];
    assign w_sel_nb   = req_num_bytes_in[NB_W*w_arb_idx +: NB_W];

    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_last_d      = r_last;
        w_gid_d       = r_gid;
        w_data_d      = r_data;
        w_nb_d        = r_nb;
        w_frame_cnt_d = r_frame_cnt;
        w_ack         = '0;
        w_reject      = '0;
        w_trigger     = 1'b0;
        w_timeout     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (enable_in && w_arb_valid) begin
                    w_last_d = w_arb_idx;
                    if (len_ok(w_sel_nb)) begin
                        w_ack     = w_arb_grant;
                        w_data_d  = w_sel_data;
                        w_nb_d    = w_sel_nb;
                        w_gid_d   = w_arb_idx;
                        w_state_d = StLaunch;
                    end else begin
                        w_reject = w_arb_grant;
                    end
                end
            end
            StLaunch: begin
                // Registered, so the encoder sees the trigger one cycle after the ack.
                w_trigger = 1'b1;
                w_cnt_d   = '0;
                w_state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (tx_done_in) begin
                    w_frame_cnt_d = r_frame_cnt + 16'd1;
                    w_cnt_d       = '0;
                    w_state_d     = StGuard;
                end else if (tx_busy_in) begin
                    w_state_d = StWaitDone;
                end else if (r_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = StGuard;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StWaitDone: begin
                if (tx_done_in || !tx_busy_in) begin
                    w_frame_cnt_d = r_frame_cnt + 16'd1;
                    w_cnt_d       = '0;
                    w_state_d     = StGuard;
                end
            end
            StGuard: begin
                if (r_cnt == GUARD_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_last      <= 2'(NUM_REQ - 1);
            r_gid       <= '0;
            r_data      <= '0;
            r_nb        <= '0;
            r_frame_cnt <= '0;
            r_ack       <= '0;
            r_reject    <= '0;
            r_trigger   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_last      <= w_last_d;
            r_gid       <= w_gid_d;
            r_data      <= w_data_d;
            r_nb        <= w_nb_d;
            r_frame_cnt <= w_frame_cnt_d;
            r_ack       <= w_ack;
            r_reject    <= w_reject;
            r_trigger   <= w_trigger;
            r_timeout   <= w_timeout;
        end
    end

    assign req_ack_out      = r_ack;
    assign req_reject_out   = r_reject;
    assign tx_data_out      = r_data;
    assign tx_num_bytes_out = r_nb;
    assign tx_trigger_out   = r_trigger;
    assign grant_id_out     = r_gid;
    assign sched_busy_out   = (r_state != StIdle);
    assign timeout_out      = r_timeout;
    assign frame_cnt_out    = r_frame_cnt;

endmodule

// File: tb/tb_picc_tx_scheduler.sv
// Directed bench for picc_tx_scheduler with shortened guard and timeout.
module tb_picc_tx_scheduler;

    localparam int unsigned NREQ  = 3;
    localparam int unsigned GUARD = 8;
    localparam int unsigned ACKTO = 20;
    localparam int         BOUND = 200;

    logic              aclk;
    logic              aresetn;
    logic              enable_in;
    logic [NREQ-1:0]   req_valid_in;
    logic [NREQ*40-1:0] req_data_in;
    logic [NREQ*3-1:0] req_num_bytes_in;
    logic [NREQ-1:0]   req_ack_out;
    logic [NREQ-1:0]   req_reject_out;
    logic [39:0]       tx_data_out;
    logic [2:0]        tx_num_bytes_out;
    logic              tx_trigger_out;
    logic              tx_busy_in;
    logic              tx_done_in;
    logic [1:0]        grant_id_out;
    logic              sched_busy_out;
    logic              timeout_out;
    logic [15:0]       frame_cnt_out;

    picc_tx_scheduler #(
        .NUM_REQ      (NREQ),
        .GUARD_CYCLES (GUARD),
        .ACK_TIMEOUT  (ACKTO)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .enable_in        (enable_in),
        .req_valid_in     (req_valid_in),
        .req_data_in      (req_data_in),
        .req_num_bytes_in (req_num_bytes_in),
        .req_ack_out      (req_ack_out),
        .req_reject_out   (req_reject_out),
        .tx_data_out      (tx_data_out),
        .tx_num_bytes_out (tx_num_bytes_out),
        .tx_trigger_out   (tx_trigger_out),
        .tx_busy_in       (tx_busy_in),
        .tx_done_in       (tx_done_in),
        .grant_id_out     (grant_id_out),
        .sched_busy_out   (sched_busy_out),
        .timeout_out      (timeout_out),
        .frame_cnt_out    (frame_cnt_out)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_frames = '0;
    logic [39:0] dat [NREQ];

    typedef struct {
        logic [2:0] valid;
        logic [8:0] nb;
        logic [2:0] exp_ack;
        logic [2:0] exp_rej;
        logic [1:0] exp_gid;
        logic [2:0] exp_nb;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sched_busy_out && n < BOUND) begin
            step();
            n++;
        end
        check("idle_reached", {63'd0, sched_busy_out}, 64'd0);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (req_ack_out == '0 && n < BOUND);
        check("ack_seen", {63'd0, (req_ack_out != '0)}, 64'd1);
    endtask

    // Encoder model: busy one cycle after trigger, then done while still busy.
    task automatic finish_frame();
        step();
        check("trigger_after_ack", {63'd0, tx_trigger_out}, 64'd1);
        check("ack_cleared", {61'd0, req_ack_out}, 64'd0);
        tx_busy_in = 1'b1;
        step();
        check("trigger_one_cycle", {63'd0, tx_trigger_out}, 64'd0);
        tx_done_in = 1'b1;
        step();
        tx_busy_in = 1'b0;
        tx_done_in = 1'b0;
        exp_frames = exp_frames + 16'd1;
        check("frame_cnt", {48'd0, frame_cnt_out}, {48'd0, exp_frames});
    endtask

    initial begin
        int n;
        int acks;
        dat[0] = 40'h00_24_90_67_35;
        dat[1] = 40'h11_22_33_44_55;
        dat[2] = 40'hA5_5A_C3_3C_0F;
        vecs[0] = '{3'b111, {3'd5, 3'd5, 3'd5}, 3'b010, 3'b000, 2'd1, 3'd5};
        vecs[1] = '{3'b011, {3'd3, 3'd3, 3'd3}, 3'b001, 3'b000, 2'd0, 3'd3};
        vecs[2] = '{3'b010, {3'd0, 3'd0, 3'd0}, 3'b000, 3'b010, 2'd0, 3'd0};
        vecs[3] = '{3'b010, {3'd0, 3'd6, 3'd0}, 3'b000, 3'b010, 2'd0, 3'd0};
        vecs[4] = '{3'b101, {3'd7, 3'd0, 3'd1}, 3'b000, 3'b100, 2'd0, 3'd0};
        vecs[5] = '{3'b110, {3'd3, 3'd1, 3'd0}, 3'b010, 3'b000, 2'd1, 3'd1};
        vecs[6] = '{3'b001, {3'd0, 3'd0, 3'd2}, 3'b001, 3'b000, 2'd0, 3'd2};

        aresetn          = 1'b0;
        enable_in        = 1'b1;
        req_valid_in     = '0;
        req_data_in      = {dat[2], dat[1], dat[0]};
        req_num_bytes_in = '0;
        tx_busy_in       = 1'b0;
        tx_done_in       = 1'b0;
        step();
        step();
        check("rst_ack", {61'd0, req_ack_out}, 64'd0);
        check("rst_reject", {61'd0, req_reject_out}, 64'd0);
        check("rst_trigger", {63'd0, tx_trigger_out}, 64'd0);
        check("rst_timeout", {63'd0, timeout_out}, 64'd0);
        check("rst_busy", {63'd0, sched_busy_out}, 64'd0);
        check("rst_frame_cnt", {48'd0, frame_cnt_out}, 64'd0);
        check("rst_tx_data", {24'd0, tx_data_out}, 64'd0);
        check("rst_grant_id", {62'd0, grant_id_out}, 64'd0);
        aresetn = 1'b1;
        step();

        // Basic frame from requester 0; valid dropped right after the ack.
        req_valid_in     = 3'b001;
        req_num_bytes_in = {3'd0, 3'd0, 3'd4};
        step();
        req_valid_in = '0;
        check("basic_ack", {61'd0, req_ack_out}, 64'd1);
        check("basic_trigger_not_yet", {63'd0, tx_trigger_out}, 64'd0);
        check("basic_nb", {61'd0, tx_num_bytes_out}, 64'd4);
        check("basic_data", {24'd0, tx_data_out}, {24'd0, dat[0]});
        finish_frame();
        check("basic_data_held", {24'd0, tx_data_out}, {24'd0, dat[0]});

        for (int i = 0; i < 7; i++) begin
            wait_idle();
            req_valid_in     = vecs[i].valid;
            req_num_bytes_in = vecs[i].nb;
            step();
            req_valid_in = '0;
            check($sformatf("v%0d_ack", i), {61'd0, req_ack_out}, {61'd0, vecs[i].exp_ack});
            check($sformatf("v%0d_reject", i), {61'd0, req_reject_out},
                  {61'd0, vecs[i].exp_rej});
            if (vecs[i].exp_ack != '0) begin
                check($sformatf("v%0d_gid", i), {62'd0, grant_id_out}, {62'd0, vecs[i].exp_gid});
                check($sformatf("v%0d_nb", i), {61'd0, tx_num_bytes_out},
                      {61'd0, vecs[i].exp_nb});
                check($sformatf("v%0d_data", i), {24'd0, tx_data_out},
                      {24'd0, dat[vecs[i].exp_gid]});
                finish_frame();
            end else begin
                step();
                check($sformatf("v%0d_no_trigger", i), {63'd0, tx_trigger_out}, 64'd0);
                check($sformatf("v%0d_reject_pulse", i), {61'd0, req_reject_out}, 64'd0);
                check($sformatf("v%0d_stay_idle", i), {63'd0, sched_busy_out}, 64'd0);
            end
        end

        // Round-robin order with all requesters held valid, starting from reset.
        wait_idle();
        aresetn = 1'b0;
        step();
        aresetn    = 1'b1;
        exp_frames = '0;
        req_valid_in     = 3'b111;
        req_num_bytes_in = {3'd4, 3'd4, 3'd4};
        for (int k = 0; k < 4; k++) begin
            wait_ack(n);
            check($sformatf("rr_order%0d", k), {62'd0, grant_id_out}, 64'(k % 3));
            if (k > 0) check($sformatf("rr_gap%0d", k), {63'd0, (n > GUARD)}, 64'd1);
            finish_frame();
        end
        req_valid_in = '0;

        // No busy from the encoder: timeout after ACKTO cycles.
        wait_idle();
        req_valid_in     = 3'b001;
        req_num_bytes_in = {3'd0, 3'd0, 3'd3};
        wait_ack(n);
        req_valid_in = '0;
        step();
        check("to_trigger", {63'd0, tx_trigger_out}, 64'd1);
        n = 0;
        while (!timeout_out && n < 2 * ACKTO) begin
            step();
            n++;
        end
        check("to_latency", 64'(n), 64'(ACKTO));
        check("to_frame_cnt", {48'd0, frame_cnt_out}, {48'd0, exp_frames});
        check("to_guard", {63'd0, sched_busy_out}, 64'd1);
        step();
        check("to_one_cycle", {63'd0, timeout_out}, 64'd0);

        // Enable dropped while waiting for busy: frame still completes, no new grants.
        wait_idle();
        req_valid_in     = 3'b001;
        req_num_bytes_in = {3'd0, 3'd0, 3'd2};
        wait_ack(n);
        step();
        enable_in  = 1'b0;
        tx_busy_in = 1'b1;
        step();
        tx_done_in = 1'b1;
        step();
        tx_busy_in = 1'b0;
        tx_done_in = 1'b0;
        exp_frames = exp_frames + 16'd1;
        check("en_frame_cnt", {48'd0, frame_cnt_out}, {48'd0, exp_frames});
        acks = 0;
        for (int c = 0; c < int'(GUARD) + 10; c++) begin
            step();
            if (req_ack_out != '0) acks++;
        end
        check("en_no_ack", 64'(acks), 64'd0);
        req_valid_in = '0;
        enable_in    = 1'b1;

        // Reset while waiting for done.
        wait_idle();
        req_valid_in     = 3'b001;
        req_num_bytes_in = {3'd0, 3'd0, 3'd5};
        wait_ack(n);
        req_valid_in = '0;
        step();
        tx_busy_in = 1'b1;
        step();
        check("rw_in_frame", {63'd0, sched_busy_out}, 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("rw_busy", {63'd0, sched_busy_out}, 64'd0);
        check("rw_frame_cnt", {48'd0, frame_cnt_out}, 64'd0);
        check("rw_data", {24'd0, tx_data_out}, 64'd0);
        check("rw_misc", {52'd0, req_ack_out, req_reject_out, tx_trigger_out, timeout_out,
                          grant_id_out}, 64'd0);
        tx_busy_in = 1'b0;
        @(negedge aclk);
        aresetn          = 1'b1;
        exp_frames       = '0;
        req_valid_in     = 3'b101;
        req_num_bytes_in = {3'd1, 3'd0, 3'd1};
        wait_ack(n);
        req_valid_in = '0;
        check("rw_first_grant", {61'd0, req_ack_out}, 64'd1);
        finish_frame();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
